load_align_unit: RTL
====================

Name: load_align_unit

Overview:
Sequential load-data path between the core's memory stage and a word-wide data memory port. Generalises load sign/zero extension to XLEN 32/64, decoded directly from RISC-V load funct3. Adds byte-lane alignment, optional two-beat handling of word-crossing misaligned loads, fault reporting, and valid/ready handshakes on both sides. One load outstanding at a time.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
ALLOW_MISALIGNED, 1, 1 = split word-crossing loads into two beats; 0 = return a fault instead.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  load request valid.
req_ready  output  1  unit can accept a request.
req_addr  input  XLEN  byte address.
req_funct3  input  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
mem_req_valid  output  1  memory read request.
mem_req_ready  input  1  memory accepts the request.
mem_addr  output  XLEN  aligned read address (low log2(XLEN/8) bits zero).
mem_rvalid  input  1  read data valid, at least 1 cycle after grant.
mem_rdata  input  XLEN  read data word.
rsp_valid  output  1  response valid.
rsp_ready  input  1  consumer accepts the response.
rsp_data  output  XLEN  aligned, extended load result.
rsp_fault  output  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3.

Behaviour:
- Reset (asynchronous, immediate): state IDLE. req_ready=1. mem_req_valid, mem_addr, rsp_valid, rsp_data and rsp_fault all 0.
- Parameters: NB=XLEN/8 bytes per word. OFS=req_addr[log2(NB)-1:0]. SIZE=1/2/4/8 bytes from funct3[1:0].
- Illegal funct3: 111 always; 011 and 110 when XLEN=32. An illegal request produces a fault response.
- Crossing: the request crosses a word when OFS+SIZE>NB.
- States:
  - IDLE: req_ready=1. Requests are accepted on req_valid&&req_ready. OFS, SIZE, signedness and the aligned base are latched.
    - Illegal funct3, or crossing with ALLOW_MISALIGNED=0: go to RESP with rsp_fault=1 and rsp_data=0. No memory access is made.
    - Otherwise go to REQ0.
  - REQ0: mem_req_valid=1, mem_addr=base. Go to WAIT0 when mem_req_ready.
  - WAIT0: on mem_rvalid, capture the word as lo. Go to REQ1 if crossing, else RESP.
  - REQ1: mem_req_valid=1, mem_addr=base+NB (wraps modulo 2^XLEN). Go to WAIT1 when mem_req_ready.
  - WAIT1: on mem_rvalid, capture the word as hi. Go to RESP.
  - RESP: rsp_valid=1, with rsp_data and rsp_fault held stable. On rsp_ready go to IDLE. A new request cannot be accepted in the same cycle; req_ready=0 in every state except IDLE.
- Data formation: shift the 2*XLEN value {hi,lo} right by OFS*8 (hi=0 for single beat). Keep the low SIZE bytes. Sign-extend from the top kept bit if signed (LB/LH/LW), zero-extend otherwise. SIZE=NB passes unchanged.
- rsp_data is registered. Latency with mem_req_ready=1 and rvalid one cycle after grant:
  - Aligned: accept at edge E, REQ0 at E+1, WAIT0 at E+2, rsp_valid from E+3.
  - Crossing: rsp_valid from E+5.
  - Fault: rsp_valid from E+1.
- mem_rvalid is ignored outside WAIT0/WAIT1.
- mem_req_valid, once raised, is held with a stable mem_addr until granted.
- Reset mid-operation aborts the load. Memory responses that arrive after reset deasserts are dropped, because the unit is in IDLE and ignores mem_rvalid there.

Decomposition:
- Shared package (riscv_pkg): load funct3 constants (F3_LB…F3_LWU), the state enum, and a size-decode function.
- One sub-module: load_extract, purely combinational. Inputs {hi,lo}, OFS, SIZE and signed. Output: XLEN result. Replaces the old fixed-width extender.

Test Plan:
1. XLEN=32. LB @0x103, word[0x100]=0x80FF_1234 -> mem_addr 0x100, rsp_data 0xFFFF_FF80, fault 0, rsp_valid 3 cycles after accept.
2. LHU @0x102, same word -> rsp_data 0x0000_80FF. LH @0x102 -> 0xFFFF_80FF.
3. LW @0x101, word[0x100]=0x4433_2211, word[0x104]=0x8877_6655 -> two requests (0x100, then 0x104), rsp_data 0x5544_3322, 5-cycle latency.
4. ALLOW_MISALIGNED=0, LH @0x103 -> no mem_req_valid, rsp_fault=1, rsp_data 0 one cycle after accept. Separately, funct3=111 -> fault.
5. Backpressure: rsp_ready=0 for 5 cycles, mem_req_ready=0 for 3 cycles -> rsp_data and mem_addr stable throughout, req_ready=0 until the response handshake.
6. XLEN=64. LWU @0x1004, word=0xDEAD_BEEF_0000_0001 -> 0x0000_0000_DEAD_BEEF. Then assert reset in WAIT0 -> outputs 0 immediately, and a stray mem_rvalid after release produces no rsp_valid.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V load definitions: funct3 encodings, load-unit state encoding
// and the access-size decode.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } lau_state_e;

  // funct3[1:0] encodes log2 of the access size in bytes.
  function automatic logic [3:0] load_size(input logic [1:0] size_code);
    return 4'd1 << size_code;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte extractor: picks SIZE bytes starting at OFS out of a
// two-word window and sign- or zero-extends them to XLEN.
module load_extract #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]         i_word,
  input  logic [$clog2(XLEN/8)-1:0] i_ofs,
  input  logic [3:0]                i_size,
  input  logic                      i_signed,
  output logic [XLEN-1:0]           o_data
);

  localparam int LW = $clog2(XLEN);

  logic [2*XLEN-1:0] w_shifted;
  logic [XLEN-1:0]   w_unused_hi;
  logic [XLEN-1:0]   w_low;
  logic [XLEN-1:0]   w_mask;
  logic [6:0]        w_nbits;
  logic [LW-1:0]     w_top;
  logic              w_sign;

  assign w_shifted = i_word >> {i_ofs, 3'b000};
  assign {w_unused_hi, w_low} = w_shifted;
  assign w_nbits = {i_size, 3'b000};
  assign w_top = LW'(w_nbits - 7'd1);

  // A full-width access shifts the ones out entirely, leaving an all-ones mask.
  assign w_mask = ~({XLEN{1'b1}} << w_nbits);
  assign w_sign = i_signed & w_low[w_top];
  assign o_data = (w_low & w_mask) | ({XLEN{w_sign}} & ~w_mask);

endmodule

// File: rtl/load_align_unit.sv
// Load data path between the memory stage and a word-wide data port: aligns,
// extends, splits word-crossing loads into two beats, and reports faults.
module load_align_unit
  import riscv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lau_state_e r_state, w_state_next;

  logic [OW-1:0]     r_ofs;
  logic [3:0]        r_size;
  logic              r_signed;
  logic              r_cross;
  logic [XLEN-1:0]   r_base;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_rsp_data;
  logic              r_rsp_fault;

  logic              w_legal;
  logic              w_req_signed;
  logic [3:0]        w_req_size;
  logic [OW-1:0]     w_req_ofs;
  logic              w_req_cross;
  logic              w_fault;
  logic [2*XLEN-1:0] w_word;
  logic [XLEN-1:0]   w_ext;

  always_comb begin
    w_legal      = 1'b0;
    w_req_signed = 1'b0;
    case (req_funct3)
      F3_LB, F3_LH, F3_LW: begin
        w_legal      = 1'b1;
        w_req_signed = 1'b1;
      end
      F3_LBU, F3_LHU: w_legal = 1'b1;
      F3_LD, F3_LWU:  w_legal = (XLEN == 64);
      default:        w_legal = 1'b0;
    endcase
  end

  assign w_req_size  = load_size(req_funct3[1:0]);
  assign w_req_ofs   = req_addr[OW-1:0];
  assign w_req_cross = (5'(w_req_ofs) + 5'(w_req_size)) > 5'(NB);
  assign w_fault     = !w_legal || (w_req_cross && !ALLOW_MISALIGNED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    rsp_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = w_fault ? ST_RESP : ST_REQ0;
        end
      end
      ST_REQ0: begin
        mem_req_valid = 1'b1;
        mem_addr      = r_base;
        if (mem_req_ready) begin
          w_state_next = ST_WAIT0;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid) begin
          w_state_next = r_cross ? ST_REQ1 : ST_RESP;
        end
      end
      ST_REQ1: begin
        mem_req_valid = 1'b1;
        mem_addr      = r_base + XLEN'(NB);
        if (mem_req_ready) begin
          w_state_next = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Second beat supplies the high word; a single beat sees zeros above.
  assign w_word = (r_state == ST_WAIT1) ? {mem_rdata, r_lo} : {{XLEN{1'b0}}, mem_rdata};

  load_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .i_word   (w_word),
    .i_ofs    (r_ofs),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ofs       <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_cross     <= 1'b0;
      r_base      <= '0;
      r_lo        <= '0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ofs       <= w_req_ofs;
            r_size      <= w_req_size;
            r_signed    <= w_req_signed;
            r_cross     <= w_req_cross;
            r_base      <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
            r_rsp_fault <= w_fault;
            r_rsp_data  <= '0;
          end
        end
        ST_WAIT0: begin
          if (mem_rvalid) begin
            r_lo <= mem_rdata;
            if (!r_cross) begin
              r_rsp_data <= w_ext;
            end
          end
        end
        ST_WAIT1: begin
          if (mem_rvalid) begin
            r_rsp_data <= w_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

endmodule
